// File: rtl/quant_wb_pkg.sv
// Shared types and helpers for the quantization write buffer.
// The optional write-merge path is enabled by defining QWB_MERGE_EN.
package quant_wb_pkg;

   localparam int SRAMC_W = 1024;
   localparam int ADRC_W  = 12;
   localparam int SRAMC_N = 32;

   function automatic int qwb_elem_width(input int data_w, input int n_elem);
      return data_w / n_elem;
   endfunction

   localparam int EW = qwb_elem_width(SRAMC_W, SRAMC_N);

   typedef enum logic {
      QWB_OP_WR = 1'b0,
      QWB_OP_RD = 1'b1
   } qwb_op_e;

   typedef struct packed {
      qwb_op_e                op;
      logic [ADRC_W-1:0]      addr;
      logic [SRAMC_W-1:0]     wdata;
      logic [0:SRAMC_N-1]     wmask;
   } qwb_entry_t;

   // Overlay the enabled elements of an incoming write onto an existing entry.
   function automatic qwb_entry_t qwb_merge_entry(input qwb_entry_t tail, input qwb_entry_t incoming);
      qwb_entry_t res;
      res = tail;
      for (int k = 0; k < SRAMC_N; k++) begin
         if (incoming.wmask[k]) begin
            res.wdata[k*EW +: EW] = incoming.wdata[k*EW +: EW];
         end
      end
      res.wmask = tail.wmask | incoming.wmask;
      return res;
   endfunction

endpackage

// File: rtl/quant_wb_storage.sv
// Entry register array: one allocate/merge write port, head and (merge builds) tail read ports.
// Storage is intentionally not reset; validity is tracked by the pointers in the top.
module quant_wb_storage
   import quant_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_alloc,
   input  logic [PW-1:0]    i_wr_idx,
   input  qwb_entry_t       i_entry,
`ifdef QWB_MERGE_EN
   input  logic             i_merge,
   input  logic [PW-1:0]    i_tail_idx,
   output qwb_entry_t       o_tail,
`endif
   input  logic [PW-1:0]    i_rd_idx,
   output qwb_entry_t       o_head
);

   qwb_entry_t r_mem [DEPTH];

   // Write port: allocation and merge are mutually exclusive by construction in the top.
   always_ff @(posedge i_clk) begin
      if (i_alloc) begin
         r_mem[i_wr_idx] <= i_entry;
      end
`ifdef QWB_MERGE_EN
      else if (i_merge) begin
         r_mem[i_tail_idx] <= qwb_merge_entry(r_mem[i_tail_idx], i_entry);
      end
`endif
   end

   assign o_head = r_mem[i_rd_idx];
`ifdef QWB_MERGE_EN
   assign o_tail = r_mem[i_tail_idx];
`endif

endmodule

// File: rtl/quant_write_buffer.sv
// Elastic in-order buffer between the quantization pipeline and the SRAMC port.
// Define QWB_MERGE_EN to let same-address writes merge into the tail entry.
module quant_write_buffer
   import quant_wb_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [SRAMC_W-1:0]   i_sramc_wdata_q,
   input  logic [ADRC_W-1:0]    i_sramc_addr_q,
   input  logic                 i_sramc_wren_q,
   input  logic [0:SRAMC_N-1]   i_sramc_wmask_q,
   input  logic                 i_sramc_rden_q,
   output logic [SRAMC_W-1:0]   o_sramc_wdata_q,
   output logic [ADRC_W-1:0]    o_sramc_addr_q,
   output logic                 o_sramc_wren_q,
   output logic [0:SRAMC_N-1]   o_sramc_wmask_q,
   output logic                 o_sramc_rden_q,
   input  logic                 i_sramc_gnt,
   output logic                 o_empty,
   output logic                 o_almost_full,
   output logic                 o_overflow,
   output logic                 o_proto_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_empty;
   logic          r_almost_full;
   logic          r_overflow;
   logic          r_proto_err;

   logic          w_enq;
   logic          w_pop;
   logic          w_full;
   logic          w_merge;
   logic          w_alloc;
   logic          w_drop;
   logic [CW-1:0] w_count_nxt;
   qwb_entry_t    w_in_entry;
   qwb_entry_t    w_head;

   assign w_enq  = i_sramc_wren_q | i_sramc_rden_q;
   assign w_pop  = ~r_empty & i_sramc_gnt;
   assign w_full = (r_count == FULL_CNT);

   // Build the entry to store; a write wins when both op strobes are set.
   always_comb begin
      w_in_entry = '0;
      if (i_sramc_wren_q) begin
         w_in_entry.op    = QWB_OP_WR;
         w_in_entry.addr  = i_sramc_addr_q;
         w_in_entry.wdata = i_sramc_wdata_q;
         w_in_entry.wmask = i_sramc_wmask_q;
      end else begin
         w_in_entry.op    = QWB_OP_RD;
         w_in_entry.addr  = i_sramc_addr_q;
         w_in_entry.wdata = '0;
         w_in_entry.wmask = '0;
      end
   end

`ifdef QWB_MERGE_EN
   qwb_entry_t    w_tail;
   logic [PW-1:0] w_tail_idx;

   assign w_tail_idx = r_wr_ptr - PW'(1);

   // A lone entry that is leaving this cycle cannot absorb a merge.
   always_comb begin
      w_merge = 1'b0;
      if (i_sramc_wren_q && (r_count != '0) && (w_tail.op == QWB_OP_WR) &&
          (w_tail.addr == i_sramc_addr_q) && !((r_count == CW'(1)) && w_pop)) begin
         w_merge = 1'b1;
      end else begin
         w_merge = 1'b0;
      end
   end
`else
   assign w_merge = 1'b0;
`endif

   assign w_alloc = w_enq & ~w_merge & (~w_full | w_pop);
   assign w_drop  = w_enq & ~w_merge & w_full & ~w_pop;

   // Occupancy after this edge.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_alloc, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers, occupancy and status flags; flags are registered from next-state count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_empty       <= 1'b1;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
         r_proto_err   <= 1'b0;
      end else begin
         if (w_alloc) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count       <= w_count_nxt;
         r_empty       <= (w_count_nxt == '0);
         r_almost_full <= (w_count_nxt >= AF_CNT);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (i_sramc_wren_q && i_sramc_rden_q) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   quant_wb_storage #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_storage (
      .i_clk      (i_clk),
      .i_alloc    (w_alloc),
      .i_wr_idx   (r_wr_ptr),
      .i_entry    (w_in_entry),
`ifdef QWB_MERGE_EN
      .i_merge    (w_merge),
      .i_tail_idx (w_tail_idx),
      .o_tail     (w_tail),
`endif
      .i_rd_idx   (r_rd_ptr),
      .o_head     (w_head)
   );

   // Present the head only while valid; unreset storage never reaches the port.
   always_comb begin
      o_sramc_wdata_q = '0;
      o_sramc_addr_q  = '0;
      o_sramc_wmask_q = '0;
      o_sramc_wren_q  = 1'b0;
      o_sramc_rden_q  = 1'b0;
      if (!r_empty) begin
         o_sramc_wdata_q = w_head.wdata;
         o_sramc_addr_q  = w_head.addr;
         o_sramc_wmask_q = w_head.wmask;
         o_sramc_wren_q  = (w_head.op == QWB_OP_WR);
         o_sramc_rden_q  = (w_head.op == QWB_OP_RD);
      end else begin
         o_sramc_wdata_q = '0;
         o_sramc_addr_q  = '0;
         o_sramc_wmask_q = '0;
         o_sramc_wren_q  = 1'b0;
         o_sramc_rden_q  = 1'b0;
      end
   end

   assign o_empty       = r_empty;
   assign o_almost_full = r_almost_full;
   assign o_overflow    = r_overflow;
   assign o_proto_err   = r_proto_err;

endmodule

// File: tb/tb_quant_write_buffer.sv
// Directed and randomized bench for quant_write_buffer against a queue-based reference model.
// Define QWB_MERGE_EN for both RTL and bench to exercise the merge configuration.
module tb_quant_write_buffer;

   localparam int W     = 1024;
   localparam int A     = 12;
   localparam int N     = 32;
   localparam int EWB   = W / N;
   localparam int DEPTH = 4;
   localparam int AFM   = 1;

   logic          clk;
   logic          rst;
   logic [W-1:0]  wdata;
   logic [A-1:0]  addr;
   logic          wren;
   logic [0:N-1]  wmask;
   logic          rden;
   logic          gnt;
   logic [W-1:0]  o_wdata;
   logic [A-1:0]  o_addr;
   logic          o_wren;
   logic [0:N-1]  o_wmask;
   logic          o_rden;
   logic          o_empty;
   logic          o_af;
   logic          o_ovf;
   logic          o_perr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit           is_wr;
      logic [A-1:0] addr;
      logic [W-1:0] data;
      logic [0:N-1] mask;
   } m_t;

   m_t mq[$];
   bit m_ovf;
   bit m_perr;

   quant_write_buffer #(.DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_sramc_wdata_q (wdata),
      .i_sramc_addr_q  (addr),
      .i_sramc_wren_q  (wren),
      .i_sramc_wmask_q (wmask),
      .i_sramc_rden_q  (rden),
      .o_sramc_wdata_q (o_wdata),
      .o_sramc_addr_q  (o_addr),
      .o_sramc_wren_q  (o_wren),
      .o_sramc_wmask_q (o_wmask),
      .o_sramc_rden_q  (o_rden),
      .i_sramc_gnt     (gnt),
      .o_empty         (o_empty),
      .o_almost_full   (o_af),
      .o_overflow      (o_ovf),
      .o_proto_err     (o_perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] d;
      for (int i = 0; i < N; i++) d[i*EWB +: EWB] = $urandom;
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_data(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      int k;
      k = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (obs[i*EWB +: EWB] !== exp[i*EWB +: EWB]) k = i;
      end
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s elem%0d observed=%h expected=%h", tag, k, obs[k*EWB +: EWB], exp[k*EWB +: EWB]);
      end
   endtask

   // Reference: FIFO of ops with pop-then-push ordering, optional tail merge.
   task automatic model_step();
      bit pop, enq, mrg, full;
      m_t e;
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_perr = 1'b0;
      end else begin
         pop  = (mq.size() != 0) && gnt;
         enq  = wren || rden;
         full = (mq.size() == DEPTH);
         mrg  = 1'b0;
`ifdef QWB_MERGE_EN
         if (wren && mq.size() > 0) begin
            e = mq[mq.size()-1];
            if (e.is_wr && e.addr == addr && !(mq.size() == 1 && pop)) mrg = 1'b1;
         end
`endif
         if (wren && rden) m_perr = 1'b1;
         if (pop) void'(mq.pop_front());
         if (mrg) begin
            e = mq[mq.size()-1];
            for (int k = 0; k < N; k++) if (wmask[k]) e.data[k*EWB +: EWB] = wdata[k*EWB +: EWB];
            e.mask = e.mask | wmask;
            mq[mq.size()-1] = e;
         end else if (enq) begin
            if (full && !pop) begin
               m_ovf = 1'b1;
            end else begin
               e.is_wr = wren;
               e.addr  = addr;
               e.data  = wren ? wdata : '0;
               e.mask  = wren ? wmask : '0;
               mq.push_back(e);
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      m_t h;
      bit ne;
      ne = (mq.size() != 0);
      if (ne) h = mq[0];
      else begin
         h.is_wr = 1'b0; h.addr = '0; h.data = '0; h.mask = '0;
      end
      chk({tag, ":empty"}, 32'(o_empty), 32'(!ne));
      chk({tag, ":af"},    32'(o_af),    32'(mq.size() >= DEPTH - AFM));
      chk({tag, ":ovf"},   32'(o_ovf),   32'(m_ovf));
      chk({tag, ":perr"},  32'(o_perr),  32'(m_perr));
      chk({tag, ":wren"},  32'(o_wren),  32'(ne && h.is_wr));
      chk({tag, ":rden"},  32'(o_rden),  32'(ne && !h.is_wr));
      chk({tag, ":addr"},  32'(o_addr),  32'(h.addr));
      chk({tag, ":mask"},  32'(o_wmask), 32'(h.mask));
      chk_data({tag, ":data"}, o_wdata, h.data);
   endtask

   task automatic drive(input bit r, input bit wr, input bit rd, input logic [A-1:0] a,
                        input logic [W-1:0] d, input logic [0:N-1] m, input bit g);
      rst = r; wren = wr; rden = rd; addr = a; wdata = d; wmask = m; gnt = g;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   logic [W-1:0] dA, dB;

   initial begin
      drive(1'b1, 1'b0, 1'b0, 12'h000, '0, '0, 1'b0);
      #1;
      tick("rst0");
      tick("rst1");

      // Latency: write appears one cycle after its enqueue edge, then pops.
      drive(1'b0, 1'b1, 1'b0, 12'h010, rand_data(), 32'hFFFF_FFFF, 1'b1);
      tick("lat_enq");
      chk("lat_wren", 32'(o_wren), 32'h1);
      chk("lat_addr", 32'(o_addr), 32'h010);
      drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0, 1'b1);
      tick("lat_pop");
      chk("lat_empty", 32'(o_empty), 32'h1);

      // Fill past capacity with grant held off.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b0, 12'(12'h100 + i), rand_data(), 32'($urandom), 1'b0);
         tick("fill");
         if (i == 1) chk("af_after2", 32'(o_af), 32'h0);
         if (i == 2) chk("af_after3", 32'(o_af), 32'h1);
         if (i == 3) chk("ovf_after4", 32'(o_ovf), 32'h0);
      end
      chk("ovf_after5", 32'(o_ovf), 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk("drain_addr", 32'(o_addr), 32'(12'h100 + i));
         drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0, 1'b1);
         tick("drain");
      end
      chk("drain_empty", 32'(o_empty), 32'h1);
      chk("ovf_sticky", 32'(o_ovf), 32'h1);

      // Full with simultaneous pop and new read.
      drive(1'b1, 1'b0, 1'b0, 12'h000, '0, '0, 1'b0);
      tick("rst2");
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b0, 12'(12'h200 + i), rand_data(), 32'($urandom), 1'b0);
         tick("fill4");
      end
      drive(1'b0, 1'b0, 1'b1, 12'h2AA, rand_data(), 32'hFFFF_FFFF, 1'b1);
      tick("fullpop");
      chk("fullpop_ovf", 32'(o_ovf), 32'h0);
      chk("fullpop_af", 32'(o_af), 32'h1);
      chk("fullpop_head", 32'(o_addr), 32'h201);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0, 1'b1);
         tick("fullpop_drain");
      end
      chk("fullpop_empty", 32'(o_empty), 32'h1);

      // Both strobes together: a single write is queued and the error latches.
      drive(1'b0, 1'b1, 1'b1, 12'h020, rand_data(), 32'h0F0F_0F0F, 1'b0);
      tick("proto");
      chk("proto_err", 32'(o_perr), 32'h1);
      chk("proto_wren", 32'(o_wren), 32'h1);
      chk("proto_rden", 32'(o_rden), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0, 1'b1);
      tick("proto_pop");
      chk("proto_one", 32'(o_empty), 32'h1);

      // Same-address writes: merged in the merge build, two entries otherwise.
      dA = rand_data();
      dB = rand_data();
      drive(1'b0, 1'b1, 1'b0, 12'h040, dA, 32'h8000_0000, 1'b0);
      tick("mrg_a");
      drive(1'b0, 1'b1, 1'b0, 12'h040, dB, 32'h4000_0000, 1'b0);
      tick("mrg_b");
`ifdef QWB_MERGE_EN
      chk("mrg_mask", 32'(o_wmask), 32'hC000_0000);
      chk("mrg_e0", o_wdata[0 +: EWB], dA[0 +: EWB]);
      chk("mrg_e1", o_wdata[EWB +: EWB], dB[EWB +: EWB]);
`else
      chk("nomrg_mask", 32'(o_wmask), 32'h8000_0000);
`endif
      drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0, 1'b1);
      tick("mrg_pop");
`ifdef QWB_MERGE_EN
      chk("mrg_count1", 32'(o_empty), 32'h1);
`else
      chk("nomrg_count2", 32'(o_empty), 32'h0);
`endif
      tick("mrg_pop2");

      // Randomized traffic with occasional reset.
      for (int c = 0; c < 400; c++) begin
         int p;
         logic [A-1:0] a;
         p = int'($urandom_range(0, 99));
         case ($urandom_range(0, 2))
            0:       a = 12'h040;
            1:       a = 12'h041;
            default: a = 12'h3C5;
         endcase
         drive(($urandom_range(0, 63) == 0), (p < 55), (p >= 45 && p < 75), a, rand_data(),
               32'($urandom), ($urandom_range(0, 99) < 45));
         tick("rand");
      end

      // Reset in the middle of traffic discards everything and clears the flags.
      drive(1'b1, 1'b1, 1'b1, 12'h055, rand_data(), 32'hFFFF_FFFF, 1'b0);
      tick("midrst0");
      tick("midrst1");
      chk("midrst_empty", 32'(o_empty), 32'h1);
      chk("midrst_ovf", 32'(o_ovf), 32'h0);
      chk("midrst_perr", 32'(o_perr), 32'h0);
      chk_data("midrst_data", o_wdata, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
